// File: rtl/seg7_pkg.sv
// seg7_pkg: shared FSM state type, digit count and active-low segment codes
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int NDIGITS = 4;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [9:0][6:0] SEG_CODE = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                          7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    return nib < 4'd10 ? SEG_CODE[nib] : BLANK;
  endfunction
endpackage

// File: rtl/seg7_dec_scan_if.sv
// seg7_dec_scan_if: display bus; master drives val, slave drives seg/dp/an/busy
interface seg7_dec_scan_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] val;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;
  logic busy;
  modport master (output val, input seg, dp, an, busy);
  modport slave (input val, output seg, dp, an, busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: shift/add-3 binary-to-BCD converter; clk, rst, start, bin_in in; busy, done, bcd out
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [WIDTH-1:0] bin;
  logic [CW-1:0] cnt;
  logic [15:0] adj;
  for (genvar d = 0; d < NDIGITS; d++) begin : g_adj
    assign adj[4*d +: 4] = bcd[4*d +: 4] >= 4'd5 ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
  end
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
              state == SHIFT ? (cnt == CW'(WIDTH - 1) ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        bin <= bin_in;
        bcd <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        {bcd, bin} <= {adj, bin} << 1;
        cnt        <= cnt + 1'b1;
      end
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: rtl/seg7_dec_scan.sv
// seg7_dec_scan: decimal 4-digit multiplexed 7-seg driver; clk, rst, bus (val in; seg, dp, an, busy out)
module seg7_dec_scan
  import seg7_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SCAN_DIV = 50000,
  parameter int LZB      = 1
) (
  input logic            clk,
  input logic            rst,
  seg7_dec_scan_if.slave bus
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [WIDTH-1:0] val_q, last_val;
  logic [15:0] disp_bcd, bcd, hi;
  logic [DW-1:0] div;
  logic [$clog2(NDIGITS)-1:0] idx;
  logic [6:0] seg_r;
  logic [NDIGITS-1:0] an_r;
  logic start, busy, done, tick, blank;
  assign start = !busy && val_q != last_val;
  bin2bcd_seq #(.WIDTH(WIDTH)) u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (val_q),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd)
  );
  assign tick  = div == DW'(SCAN_DIV - 1);
  assign hi    = disp_bcd >> {idx, 2'b00};
  assign blank = LZB != 0 && idx != '0 && hi == 16'h0;
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q    <= '0;
      last_val <= '0;
      disp_bcd <= '0;
      div      <= '0;
      idx      <= '0;
      seg_r    <= BLANK;
      an_r     <= '1;
    end else begin
      val_q <= bus.val;
      div   <= tick ? '0 : div + 1'b1;
      if (start) last_val <= val_q;
      if (done) disp_bcd <= bcd;
      if (tick) begin
        idx   <= idx + 1'b1;
        seg_r <= blank ? BLANK : seg_code(hi[3:0]);
        an_r  <= blank ? '1 : ~(NDIGITS'(1) << idx);
      end
    end
  end
  assign bus.seg  = seg_r;
  assign bus.an   = an_r;
  assign bus.dp   = 1'b1;
  assign bus.busy = busy;
endmodule

// File: tb/tb_seg7_dec_scan.sv
// tb_seg7_dec_scan: directed table-driven bench for seg7_dec_scan
module tb_seg7_dec_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seg7_dec_scan_if #(.WIDTH(4))  b4 ();
  seg7_dec_scan_if #(.WIDTH(4))  b4n ();
  seg7_dec_scan_if #(.WIDTH(13)) b13 ();
  seg7_dec_scan #(.WIDTH(4),  .SCAN_DIV(4), .LZB(1)) u4  (.clk(clk), .rst(rst), .bus(b4));
  seg7_dec_scan #(.WIDTH(4),  .SCAN_DIV(4), .LZB(0)) u4n (.clk(clk), .rst(rst), .bus(b4n));
  seg7_dec_scan #(.WIDTH(13), .SCAN_DIV(4), .LZB(1)) u13 (.clk(clk), .rst(rst), .bus(b13));
  typedef struct {
    int v;
    logic [3:0][3:0] an;
    logic [3:0][6:0] seg;
    logic [3:0][6:0] segn;
  } vec_t;
  vec_t tbl[5];
  int pass_n = 0;
  int total = 0;
  int sel = 0;
  logic [3:0] an_m;
  logic [6:0] seg_m;
  logic busy_m, dp_m;
  logic [3:0] cap_an[4];
  logic [6:0] cap_seg[4];
  logic [15:0] log_q[$];
  logic [15:0] last_disp = 16'h0;
  always_comb begin
    an_m   = sel == 0 ? b4.an   : sel == 1 ? b4n.an   : b13.an;
    seg_m  = sel == 0 ? b4.seg  : sel == 1 ? b4n.seg  : b13.seg;
    busy_m = sel == 0 ? b4.busy : sel == 1 ? b4n.busy : b13.busy;
    dp_m   = sel == 0 ? b4.dp   : sel == 1 ? b4n.dp   : b13.dp;
  end
  always @(negedge clk) begin
    if (u4.disp_bcd != last_disp) log_q.push_back(u4.disp_bcd);
    last_disp = u4.disp_bcd;
  end
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic set_val(input int v);
    b4.val  = 4'(v);
    b4n.val = 4'(v);
  endtask
  task automatic conv(output int first, output int highs);
    first = -1;
    highs = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (busy_m) begin
        highs++;
        if (first < 0) first = j;
      end
    end
  endtask
  task automatic scan();
    logic prev, cur, ok;
    ok = 1'b0;
    prev = an_m == 4'b1110;
    for (int j = 0; j < 80 && !ok; j++) begin
      @(negedge clk);
      cur = an_m == 4'b1110;
      if (cur && !prev) ok = 1'b1;
      prev = cur;
    end
    check("scan_sync", int'(ok), 1);
    cap_an[0] = an_m;
    cap_seg[0] = seg_m;
    for (int k = 1; k < 4; k++) begin
      repeat (4) @(negedge clk);
      cap_an[k] = an_m;
      cap_seg[k] = seg_m;
    end
  endtask
  initial begin
    int first, highs, prev_v, rises, hi_n, lows_in, lowrun, t7;
    logic pb;
    tbl[0] = '{v:0,  an:{4'hF, 4'hF, 4'hF, 4'hE}, seg:{7'h7F, 7'h7F, 7'h7F, 7'h40}, segn:{7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[1] = '{v:9,  an:{4'hF, 4'hF, 4'hF, 4'hE}, seg:{7'h7F, 7'h7F, 7'h7F, 7'h10}, segn:{7'h40, 7'h40, 7'h40, 7'h10}};
    tbl[2] = '{v:15, an:{4'hF, 4'hF, 4'hD, 4'hE}, seg:{7'h7F, 7'h7F, 7'h79, 7'h12}, segn:{7'h40, 7'h40, 7'h79, 7'h12}};
    tbl[3] = '{v:10, an:{4'hF, 4'hF, 4'hD, 4'hE}, seg:{7'h7F, 7'h7F, 7'h79, 7'h40}, segn:{7'h40, 7'h40, 7'h79, 7'h40}};
    tbl[4] = '{v:7,  an:{4'hF, 4'hF, 4'hF, 4'hE}, seg:{7'h7F, 7'h7F, 7'h7F, 7'h78}, segn:{7'h40, 7'h40, 7'h40, 7'h78}};
    set_val(0);
    b13.val = 13'd0;
    repeat (2) @(negedge clk);
    check("rst_seg", int'(seg_m), 'h7F);
    check("rst_an", int'(an_m), 'hF);
    check("rst_dp", int'(dp_m), 1);
    check("rst_busy", int'(busy_m), 0);
    check("rst_disp", int'(u4.disp_bcd), 0);
    rst = 1'b0;
    prev_v = 0;
    foreach (tbl[r]) begin
      set_val(tbl[r].v);
      sel = 0;
      conv(first, highs);
      check($sformatf("busy_len v=%0d", tbl[r].v), highs, tbl[r].v != prev_v ? 5 : 0);
      check($sformatf("busy_start v=%0d", tbl[r].v), first, tbl[r].v != prev_v ? 2 : -1);
      check($sformatf("disp v=%0d", tbl[r].v), int'(u4.disp_bcd), ((tbl[r].v / 10) << 4) | (tbl[r].v % 10));
      prev_v = tbl[r].v;
      scan();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("an v=%0d slot%0d", tbl[r].v, k), int'(cap_an[k]), int'(tbl[r].an[k]));
        check($sformatf("seg v=%0d slot%0d", tbl[r].v, k), int'(cap_seg[k]), int'(tbl[r].seg[k]));
      end
      sel = 1;
      scan();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("an_nolzb v=%0d slot%0d", tbl[r].v, k), int'(cap_an[k]), int'(~(4'b0001 << k) & 4'hF));
        check($sformatf("seg_nolzb v=%0d slot%0d", tbl[r].v, k), int'(cap_seg[k]), int'(tbl[r].segn[k]));
      end
    end
    sel = 2;
    b13.val = 13'd8191;
    conv(first, highs);
    check("busy_len w13", highs, 14);
    check("busy_start w13", first, 2);
    check("disp w13", int'(u13.disp_bcd), 'h8191);
    scan();
    check("w13 slot0", int'(cap_seg[0]), 'h79);
    check("w13 slot1", int'(cap_seg[1]), 'h10);
    check("w13 slot2", int'(cap_seg[2]), 'h79);
    check("w13 slot3", int'(cap_seg[3]), 'h00);
    check("w13 an3", int'(cap_an[3]), 'h7);
    sel = 0;
    set_val(0);
    conv(first, highs);
    log_q.delete();
    rises = 0;
    hi_n = 0;
    lows_in = 0;
    lowrun = 0;
    t7 = -1;
    pb = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 0) set_val(3);
      if (i == 2) set_val(12);
      if (i == t7) set_val(7);
      @(negedge clk);
      if (busy_m && !pb) begin
        rises++;
        if (rises > 1) lows_in += lowrun;
        if (rises == 2) t7 = i + 2;
      end
      if (busy_m) hi_n++;
      lowrun = busy_m ? 0 : lowrun + 1;
      pb = busy_m;
    end
    check("seq_rises", rises, 3);
    check("seq_busy_cycles", hi_n, 15);
    check("seq_idle_gaps", lows_in, 2);
    check("seq_log_len", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("seq_log0", int'(log_q[0]), 'h0003);
      check("seq_log1", int'(log_q[1]), 'h0012);
      check("seq_log2", int'(log_q[2]), 'h0007);
    end
    scan();
    check("seq_final_seg", int'(cap_seg[0]), 'h78);
    check("seq_final_an", int'(cap_an[0]), 'hE);
    set_val(6);
    for (int j = 0; j < 10 && !busy_m; j++) @(negedge clk);
    check("rstmid_busy_seen", int'(busy_m), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_seg", int'(seg_m), 'h7F);
    check("rstmid_an", int'(an_m), 'hF);
    check("rstmid_dp", int'(dp_m), 1);
    check("rstmid_busy", int'(busy_m), 0);
    check("rstmid_disp", int'(u4.disp_bcd), 0);
    rst = 1'b0;
    conv(first, highs);
    check("rerun_busy_len", highs, 5);
    check("rerun_busy_start", first, 2);
    check("rerun_disp", int'(u4.disp_bcd), 'h0006);
    scan();
    check("rerun_seg", int'(cap_seg[0]), 'h02);
    $display("%0d/%0d checks passed", pass_n, total);
    $finish;
  end
endmodule
